// File: rtl/sram_port0_ctrl.sv
// sram_port0_ctrl: valid/ready request/response front end for port 0 of a single-port SRAM macro.
// Define SRAM_CTRL_MEM_INIT_EN to zero-fill the whole array after reset (INIT state) before service.
module sram_port0_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,

  output logic                  init_done
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_RSP
  } state_e;

`ifdef SRAM_CTRL_MEM_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_IDLE;
`endif

  state_e                state_q,     state_d;
  logic                  csb_q,       csb_d;
  logic                  web_q,       web_d;
  logic [NUM_WMASKS-1:0] wmask_q,     wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] din_q,       din_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef SRAM_CTRL_MEM_INIT_EN
  logic [ADDR_WIDTH-1:0] init_cnt_q,  init_cnt_d;
`endif

  always_comb begin
    // NOTE: every _d gets its default before the case, so no path through it can infer a latch.
    state_d     = state_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    wmask_d     = wmask_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef SRAM_CTRL_MEM_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif

    case (state_q)
      ST_INIT: begin
`ifdef SRAM_CTRL_MEM_INIT_EN
        // One full-width zero write per cycle; leave after the top address is issued.
        csb_d      = 1'b0;
        web_d      = 1'b0;
        wmask_d    = '1;
        addr_d     = init_cnt_q;
        din_d      = '0;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == '1) begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_IDLE: begin
        if (req_valid) begin
          csb_d  = 1'b0;
          addr_d = req_addr;
          if (req_we) begin
            web_d   = 1'b0;
            wmask_d = req_wmask;
            din_d   = req_wdata;
          end else begin
            wmask_d = '0;
            state_d = ST_RD1;
          end
        end
      end

      // SRAM samples the read address on the next edge and presents dout after it.
      ST_RD1: state_d = ST_RD2;

      ST_RD2: begin
        rsp_rdata_d = sram_dout0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = RESET_STATE;
    endcase
  end

  // NOTE: state and every SRAM pin are flops updated with non-blocking assignments,
  // so req_* never reaches sram_* combinationally and all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      wmask_q     <= wmask_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef SRAM_CTRL_MEM_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
    end
  end

  // INIT is only ever entered from reset, so leaving it marks the block serviceable.
  assign init_done = (state_q != ST_INIT);
`else
  assign init_done = 1'b1;
`endif

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Self-checking bench for sram_port0_ctrl: behavioural SRAM, timeline reference model, directed + random stimulus.
// Works with or without SRAM_CTRL_MEM_INIT_EN defined.
`timescale 1ns/1ps
module tb_sram_port0_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int NW = 1 << AW;
`ifdef SRAM_CTRL_MEM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [MW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_csb0, sram_web0;
  logic [MW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0, sram_dout0;
  logic          init_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_port0_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wmask(req_wmask),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .init_done(init_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Power-up contents of never-written words: a fixed per-address pattern.
  function automatic logic [DW-1:0] pat(input int a);
    logic [31:0] k;
    k = 32'h9E37_79B9;
    return k * (a + 1);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] base, input logic [DW-1:0] d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = base;
    for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port SRAM: samples on the rising edge, registered read data.
  logic [DW-1:0] sram_mem [NW];
  logic [NW-1:0] sram_written = '0;

  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        sram_mem[sram_addr0]     <= merge(sram_written[sram_addr0] ? sram_mem[sram_addr0]
                                                                   : pat(int'(sram_addr0)),
                                          sram_din0, sram_wmask0);
        sram_written[sram_addr0] <= 1'b1;
      end else begin
        sram_dout0 <= sram_written[sram_addr0] ? sram_mem[sram_addr0] : pat(int'(sram_addr0));
      end
    end
  end

  // Reference model: expected memory plus a timeline of what each edge must do.
  logic [DW-1:0] ref_mem [NW];
  int            init_idx;
  int            rd_cnt;
  bit            rd_busy, rsp_out;
  logic [DW-1:0] rsp_data;
  logic          exp_csb, exp_web;
  logic [MW-1:0] exp_wmask;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;

  task automatic model_reset();
    init_idx  = INIT_EN ? 0 : NW;
    rd_busy   = 1'b0;
    rsp_out   = 1'b0;
    rd_cnt    = 0;
    exp_csb   = 1'b1;
    exp_web   = 1'b1;
    exp_wmask = '0;
    exp_addr  = '0;
    exp_din   = '0;
  endtask

  task automatic model_compare();
    check("req_ready",   req_ready,   !rd_busy && (init_idx == NW));
    check("init_done",   init_done,   init_idx == NW);
    check("rsp_valid",   rsp_valid,   rsp_out);
    if (rsp_out) check("rsp_rdata", rsp_rdata, rsp_data);
    check("sram_csb0",   sram_csb0,   exp_csb);
    check("sram_web0",   sram_web0,   exp_web);
    check("sram_wmask0", sram_wmask0, exp_wmask);
    check("sram_addr0",  sram_addr0,  exp_addr);
    check("sram_din0",   sram_din0,   exp_din);
  endtask

  // Effect of the coming rising edge, from the inputs as they stand now.
  task automatic model_step();
    if (init_idx < NW) begin
      exp_csb           = 1'b0;
      exp_web           = 1'b0;
      exp_wmask         = '1;
      exp_addr          = AW'(init_idx);
      exp_din           = '0;
      ref_mem[init_idx] = '0;
      init_idx++;
    end else if (!rd_busy && req_valid) begin
      exp_csb  = 1'b0;
      exp_addr = req_addr;
      if (req_we) begin
        exp_web           = 1'b0;
        exp_wmask         = req_wmask;
        exp_din           = req_wdata;
        ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
      end else begin
        exp_web   = 1'b1;
        exp_wmask = '0;
        rd_busy   = 1'b1;
        rd_cnt    = 2;
        rsp_data  = ref_mem[req_addr];
      end
    end else begin
      exp_csb = 1'b1;
      exp_web = 1'b1;
      if (rsp_out) begin
        if (rsp_ready) begin
          rsp_out = 1'b0;
          rd_busy = 1'b0;
        end
      end else if (rd_busy) begin
        rd_cnt--;
        if (rd_cnt == 0) rsp_out = 1'b1;
      end
    end
  endtask

  initial begin : model
    for (int i = 0; i < NW; i++) ref_mem[i] = pat(i);
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        model_compare();
      end else begin
        model_compare();
        model_step();
      end
    end
  end

  // Directed helpers; all run from just after a rising edge.
  task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [MW-1:0] m);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    req_wmask = MW'($urandom);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, rsp_valid, 1'b1);
  endtask

  task automatic read_expect(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    send(1'b0, a, $urandom, MW'($urandom));
    wait_rsp({name, "_valid"});
    check(name, rsp_rdata, exp);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_init", init_done, 1'b1);
  endtask

  initial begin : stim
    int n;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wmask = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_csb0",      sram_csb0,   1'b1);
    check("rst_web0",      sram_web0,   1'b1);
    check("rst_wmask0",    sram_wmask0, 4'h0);
    check("rst_addr0",     sram_addr0,  9'h000);
    check("rst_din0",      sram_din0,   32'h0);
    check("rst_rsp_valid", rsp_valid,   1'b0);
    check("rst_rsp_rdata", rsp_rdata,   32'h0);
    check("rst_req_ready", req_ready,   !INIT_EN);
    check("rst_init_done", init_done,   !INIT_EN);
    #1 rst_n = 1'b1;

    // Init latency counted in rising edges after reset release.
    n = 0;
    if (INIT_EN) begin
      while (!init_done && n < 2000) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("init_latency", n, 512);
      read_expect(9'h1A3, 32'h0000_0000, "init_1a3");
    end else begin
      check("init_done_tied", init_done, 1'b1);
      @(posedge clk);
      #1;
    end

    // Read right after write to the same word.
    send(1'b1, 9'h005, 32'hDEAD_BEEF, 4'hF);
    send(1'b0, 9'h005, 32'h0, 4'h0);
    check("r031_lat0", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    check("r031_lat1", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    check("r031_lat2", rsp_valid, 1'b1);
    check("r031_data", rsp_rdata, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("r031_drop", rsp_valid, 1'b0);

    // Byte-masked overwrite.
    send(1'b1, 9'h010, 32'h1122_3344, 4'hF);
    send(1'b1, 9'h010, 32'hAABB_CCDD, 4'h5);
    read_expect(9'h010, 32'h11BB_33DD, "r032_merge");

    // Back-to-back writes at the top of the address space.
    send(1'b1, 9'h000, 32'h0BAD_F00D, 4'hF);
    @(posedge clk);
    #1;
    check("b2b_pre_csb", sram_csb0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, AW'(9'h1FC + i), 32'hC0DE_0000 + 32'(i), 4'hF);
      check("b2b_csb_low", sram_csb0, 1'b0);
      check("b2b_addr",    sram_addr0, 9'h1FC + 9'(i));
      check("b2b_ready",   req_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    check("b2b_post_csb", sram_csb0, 1'b1);
    for (int i = 0; i < 4; i++) read_expect(AW'(9'h1FC + i), 32'hC0DE_0000 + 32'(i), "b2b_readback");
    read_expect(9'h000, 32'h0BAD_F00D, "b2b_nowrap");

    // Zero-mask write leaves memory untouched.
    send(1'b1, 9'h005, 32'h1234_5678, 4'h0);
    read_expect(9'h005, 32'hDEAD_BEEF, "zero_mask");

    // Response back-pressure.
    send(1'b0, 9'h010, 32'h0, 4'h0);
    wait_rsp("r034_valid");
    check("r034_data", rsp_rdata, 32'h11BB_33DD);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("r034_hold_data",  rsp_rdata, 32'h11BB_33DD);
      check("r034_hold_valid", rsp_valid, 1'b1);
      check("r034_hold_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("r034_drop",  rsp_valid, 1'b0);
    check("r034_ready", req_ready, 1'b1);

    // Reset asserted while the read sits in RD2.
    send(1'b1, 9'h033, 32'hCAFE_F00D, 4'hF);
    send(1'b0, 9'h033, 32'h0, 4'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("r035_csb",   sram_csb0, 1'b1);
    check("r035_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_init();
    for (int i = 0; i < 6; i++) begin
      check("r035_no_rsp", rsp_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    read_expect(9'h033, INIT_EN ? 32'h0 : 32'hCAFE_F00D, "r035_after");

    // Random traffic, judged cycle by cycle by the reference model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_we    = 1'($urandom_range(0, 1));
      req_wmask = MW'($urandom);
      req_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
